// File: rtl/wb_stage_pipe.sv
// Writeback stage: captures the MEM/WB payload, formats load data, and drives the register-file write port. Optional retire counter under WB_RETIRE_CNT_EN.
// Latency: one cycle from sampled inputs to registered outputs.
// Backpressure: o_in_ready = !i_stall; while stalled, every output register holds and flush is ignored.
module wb_stage_pipe #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int CNT_WIDTH = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [1:0]           i_wb_sel,
    input  logic [WORD_SIZE-1:0] i_alu_data,
    input  logic [WORD_SIZE-1:0] i_memory_data,
    input  logic [WORD_SIZE-1:0] i_pc_plus4,
    input  logic [WORD_SIZE-1:0] i_aux_data,
    input  logic [2:0]           i_load_funct3,
    input  logic [1:0]           i_byte_off,
    input  logic [REG_SEL-1:0]   i_rd,
    input  logic                 i_reg_write,
    output logic                 o_wb_valid,
    output logic [WORD_SIZE-1:0] o_write_data,
    output logic [REG_SEL-1:0]   o_rd_out,
    output logic                 o_reg_write_out,
    output logic                 o_load_misaligned,
    output logic [CNT_WIDTH-1:0] o_retire_count
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_ALU = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_PC4 = 2'd2;

    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [WORD_SIZE-1:0] w_load_val;
    logic [WORD_SIZE-1:0] w_sel_val;
    logic                 w_misaligned;
    logic                 w_capture;

    logic                 r_wb_valid;
    logic [WORD_SIZE-1:0] r_write_data;
    logic [REG_SEL-1:0]   r_rd;
    logic                 r_reg_write;
    logic                 r_misaligned;

    assign o_in_ready = !i_stall;
    assign w_capture  = i_in_valid && !i_flush;

    // Pick the addressed byte / halfword lane out of the aligned memory word
    always_comb begin
        w_byte = i_memory_data[{i_byte_off, 3'b000} +: 8];
        w_half = i_memory_data[{i_byte_off[1], 4'b0000} +: 16];
    end

    // Extend the selected lane according to the load type; reserved encodings give zero
    always_comb begin
        w_load_val = '0;
        case (i_load_funct3)
            F3_LB:   w_load_val = {{(WORD_SIZE-8){w_byte[7]}}, w_byte};
            F3_LH:   w_load_val = {{(WORD_SIZE-16){w_half[15]}}, w_half};
            F3_LW:   w_load_val = WORD_SIZE'(i_memory_data[31:0]);
            F3_LBU:  w_load_val = WORD_SIZE'(w_byte);
            F3_LHU:  w_load_val = WORD_SIZE'(w_half);
            default: w_load_val = '0;
        endcase
    end

    // Misalignment only matters when the result actually comes from memory
    always_comb begin
        w_misaligned = 1'b0;
        if (i_wb_sel == SEL_MEM) begin
            case (i_load_funct3)
                F3_LH, F3_LHU: w_misaligned = i_byte_off[0];
                F3_LW:         w_misaligned = (i_byte_off != 2'b00);
                default:       w_misaligned = 1'b0;
            endcase
        end
    end

    // Result source mux
    always_comb begin
        case (i_wb_sel)
            SEL_ALU: w_sel_val = i_alu_data;
            SEL_MEM: w_sel_val = w_load_val;
            SEL_PC4: w_sel_val = i_pc_plus4;
            default: w_sel_val = i_aux_data;
        endcase
    end

    // Stage registers: stall holds everything, otherwise capture or insert a bubble
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid   <= 1'b0;
            r_write_data <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!i_stall) begin
            if (w_capture) begin
                r_wb_valid   <= 1'b1;
                r_write_data <= w_sel_val;
                r_rd         <= i_rd;
                r_reg_write  <= i_reg_write && (i_rd != '0) && !w_misaligned;
                r_misaligned <= w_misaligned;
            end else begin
                // Bubble or flush: data and rd keep their old contents
                r_wb_valid   <= 1'b0;
                r_reg_write  <= 1'b0;
                r_misaligned <= 1'b0;
            end
        end
    end

    assign o_wb_valid        = r_wb_valid;
    assign o_write_data      = r_write_data;
    assign o_rd_out          = r_rd;
    assign o_reg_write_out   = r_reg_write;
    assign o_load_misaligned = r_misaligned;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_WIDTH-1:0] r_retire_cnt;

    // Count each instruction as it leaves the stage (valid and not held by stall); wraps naturally
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retire_cnt <= '0;
        end else if (!i_stall && r_wb_valid) begin
            r_retire_cnt <= r_retire_cnt + CNT_WIDTH'(1);
        end
    end

    assign o_retire_count = r_retire_cnt;
`else
    assign o_retire_count = '0;
`endif

endmodule
